// File: rtl/fp_div_iter.sv
// Iterative restoring floating-point divider: one quotient bit per cycle, then a normalize/round cycle.
// FP_DIV_ITER_RNE_EN selects round-to-nearest-even; when undefined the result is truncated.
module fp_div_iter #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] opA,
  input  logic [W-1:0] opB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic         overflow,
  output logic         underflow,
  output logic         inexact,
  output logic         dbz
);

  localparam int QW = MAN_W + 3;
  localparam int RW = MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW + 1);
  localparam logic [EXP_W-1:0]     EMAX  = '1;
  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EOVF  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EZERO = '0;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] q;
    logic         ovf;
    logic         unf;
    logic         inx;
    logic         dbz;
  } res_t;

  state_t state, state_nxt;

  logic                 sgn;
  logic [RW-1:0]        rem;
  logic [MAN_W:0]       dvs;
  logic [QW-1:0]        qbits;
  logic signed [EW-1:0] exp_r;
  logic [CW-1:0]        cnt;
  res_t                 res;

  // operand classification straight off the inputs, used on the accept edge
  logic [EXP_W-1:0] ea, eb;
  logic             s, za, zb, ia, ib, spec_hit;
  res_t             spec_res;

  assign ea       = opA[W-2 -: EXP_W];
  assign eb       = opB[W-2 -: EXP_W];
  assign s        = opA[W-1] ^ opB[W-1];
  assign za       = (ea == '0);
  assign zb       = (eb == '0);
  assign ia       = (ea == EMAX);
  assign ib       = (eb == EMAX);
  assign spec_hit = za | zb | ia | ib;

  always_comb begin
    spec_res        = '0;
    spec_res.q[W-1] = s;
    if ((za && zb) || (ia && ib)) begin
      spec_res.q[W-2 -: EXP_W] = EMAX;
      spec_res.q[MAN_W-1]      = 1'b1;
      spec_res.dbz             = za && zb;
    end else if (zb) begin
      spec_res.q[W-2 -: EXP_W] = EMAX;
      spec_res.ovf             = 1'b1;
      spec_res.dbz             = 1'b1;
    end else if (!za && ia) begin
      spec_res.q[W-2 -: EXP_W] = EMAX;
    end
  end

  // restoring step: remainder stays below 2*divisor, so the shift never drops a set bit
  logic          qbit;
  logic [RW-1:0] rem_sel, rem_nxt;

  always_comb begin
    qbit    = (rem >= RW'(dvs));
    rem_sel = qbit ? (rem - RW'(dvs)) : rem;
    rem_nxt = {rem_sel[RW-2:0], 1'b0};
  end

  logic                 norm, guard, sticky, inc;
  logic [QW-1:0]        qn;
  logic signed [EW-1:0] en, ef;
  logic [MAN_W-1:0]     mant, mf;
  logic [MAN_W:0]       mant_inc;
  res_t                 norm_res;

  always_comb begin
    norm   = qbits[QW-1];
    qn     = norm ? qbits : {qbits[QW-2:0], 1'b0};
    en     = norm ? exp_r : exp_r - EW'(1);
    mant   = qn[QW-2:2];
    guard  = qn[1];
    sticky = qn[0] | (rem != '0);
`ifdef FP_DIV_ITER_RNE_EN
    inc    = guard & (sticky | mant[0]);
`else
    inc    = 1'b0;
`endif
    mant_inc = {1'b0, mant} + (MAN_W + 1)'(inc);
    ef       = en + EW'(mant_inc[MAN_W]);
    mf       = mant_inc[MAN_W] ? '0 : mant_inc[MAN_W-1:0];

    norm_res        = '0;
    norm_res.q[W-1] = sgn;
    if (ef >= EOVF) begin
      norm_res.q[W-2 -: EXP_W] = EMAX;
      norm_res.ovf             = 1'b1;
      norm_res.inx             = 1'b1;
    end else if (ef <= EZERO) begin
      norm_res.unf = 1'b1;
      norm_res.inx = 1'b1;
    end else begin
      norm_res.q   = {sgn, ef[EXP_W-1:0], mf};
      norm_res.inx = guard | sticky;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = spec_hit ? DONE : DIV;
      DIV:  if (cnt == CW'(QW - 1)) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  // specials enter DONE on the accept edge; out_valid follows one edge later
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sgn       <= 1'b0;
      rem       <= '0;
      dvs       <= '0;
      qbits     <= '0;
      exp_r     <= '0;
      cnt       <= '0;
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn   <= s;
          rem   <= {1'b0, 1'b1, opA[MAN_W-1:0]};
          dvs   <= {1'b1, opB[MAN_W-1:0]};
          exp_r <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
          qbits <= '0;
          cnt   <= '0;
          if (spec_hit) res <= spec_res;
        end
        DIV: begin
          qbits <= {qbits[QW-2:0], qbit};
          rem   <= rem_nxt;
          cnt   <= cnt + CW'(1);
        end
        NORM: begin
          res       <= norm_res;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign quotient  = res.q;
  assign overflow  = res.ovf;
  assign underflow = res.unf;
  assign inexact   = res.inx;
  assign dbz       = res.dbz;

endmodule

// File: tb/tb_fp_div_iter.sv
// Scoreboard bench for fp_div_iter at default widths (half precision).
module tb_fp_div_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quotient;
  logic        overflow, underflow, inexact, dbz;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] q;
    logic [3:0]  fl;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];

`ifdef FP_DIV_ITER_RNE_EN
  localparam logic [15:0] Q_ROUND = 16'h3EAB;
`else
  localparam logic [15:0] Q_ROUND = 16'h3EAA;
`endif

  // flag nibble order: overflow, underflow, inexact, dbz
  assign flags = {overflow, underflow, inexact, dbz};

  fp_div_iter dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .opA(opA), .opB(opB),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient),
    .overflow(overflow), .underflow(underflow), .inexact(inexact), .dbz(dbz)
  );

  always #5 clock = ~clock;

  function automatic exp_t mk(input logic [15:0] q, input logic [3:0] fl, input int lat);
    mk.q   = q;
    mk.fl  = fl;
    mk.lat = 8'(lat);
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clock); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL send_ready in_ready=%0b want 1", in_ready);
    end
    opA = a; opB = b; in_valid = 1'b1;
    @(posedge clock);
    sb.push_back(e);
    #1;
    in_valid = 1'b0; opA = 16'($urandom); opB = 16'($urandom);
  endtask

  task automatic recv(input int stall);
    exp_t e;
    int lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clock); #1; lat++; end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL scoreboard_empty got out_valid=%0b", out_valid);
      e = '0;
    end else e = sb.pop_front();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL out_valid_timeout got %0b want 1", out_valid); end
    checks++;
    if (quotient !== e.q) begin errors++; $display("FAIL quotient got %h want %h", quotient, e.q); end
    checks++;
    if (flags !== e.fl) begin errors++; $display("FAIL flags got %b want %b (q %h)", flags, e.fl, e.q); end
    checks++;
    if (lat !== int'(e.lat)) begin errors++; $display("FAIL latency got %0d want %0d (q %h)", lat, e.lat, e.q); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_done got %0b want 0", in_ready); end
    for (int i = 0; i < stall; i++) begin
      @(posedge clock); #1;
      checks++;
      if ({out_valid, in_ready, quotient, flags} !== {1'b1, 1'b0, e.q, e.fl}) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got v=%0b r=%0b q=%h f=%b want v=1 r=0 q=%h f=%b",
                 i, out_valid, in_ready, quotient, flags, e.q, e.fl);
      end
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL release got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++;
    if (quotient !== 16'h0000) begin errors++; $display("FAIL reset_quotient got %h want 0000", quotient); end
    checks++;
    if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_normal();
    logic [15:0] av[6] = '{16'h3C00, 16'h4500, 16'h4000, 16'hC400, 16'h3C00, 16'h7BFF};
    logic [15:0] bv[6] = '{16'h4000, 16'h4200, 16'h3C00, 16'h4000, 16'h4200, 16'h3C00};
    logic [15:0] qv[6] = '{16'h3800, Q_ROUND,  16'h4000, 16'hC000, 16'h3555, 16'h7BFF};
    logic [3:0]  fv[6] = '{4'b0000,  4'b0010,  4'b0000,  4'b0000,  4'b0010,  4'b0000};
    for (int i = 0; i < 6; i++) begin
      send(av[i], bv[i], mk(qv[i], fv[i], 14));
      recv(0);
    end
  endtask

  task automatic test_exp_bounds();
    logic [15:0] av[5] = '{16'h7BFF, 16'h0400, 16'h7800, 16'h0400, 16'h0400};
    logic [15:0] bv[5] = '{16'h0400, 16'h7BFF, 16'h3800, 16'h3C00, 16'h4000};
    logic [15:0] qv[5] = '{16'h7C00, 16'h0000, 16'h7C00, 16'h0400, 16'h0000};
    logic [3:0]  fv[5] = '{4'b1010,  4'b0110,  4'b1010,  4'b0000,  4'b0110};
    for (int i = 0; i < 5; i++) begin
      send(av[i], bv[i], mk(qv[i], fv[i], 14));
      recv(0);
    end
  endtask

  task automatic test_special();
    logic [15:0] av[11] = '{16'hBC00, 16'h0000, 16'h0000, 16'h8000, 16'h7C00, 16'h7C00,
                            16'h4000, 16'h0001, 16'h4000, 16'hC000, 16'h7C55};
    logic [15:0] bv[11] = '{16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h7C00, 16'hC000,
                            16'h7C00, 16'h4000, 16'h0200, 16'hFC00, 16'h4000};
    logic [15:0] qv[11] = '{16'hFC00, 16'h0000, 16'h7E00, 16'hFE00, 16'h7E00, 16'hFC00,
                            16'h0000, 16'h0000, 16'h7C00, 16'h0000, 16'h7C00};
    logic [3:0]  fv[11] = '{4'b1001,  4'b0000,  4'b0001,  4'b0001,  4'b0000,  4'b0000,
                            4'b0000,  4'b0000,  4'b1001,  4'b0000,  4'b0000};
    for (int i = 0; i < 11; i++) begin
      send(av[i], bv[i], mk(qv[i], fv[i], 1));
      recv(0);
    end
  endtask

  task automatic test_stall();
    send(16'h4500, 16'h4200, mk(Q_ROUND, 4'b0010, 14));
    recv(5);
  endtask

  // next operands sit on the bus with in_valid high while the previous op runs
  task automatic test_back_to_back();
    logic [15:0] av[3] = '{16'h3C00, 16'hBC00, 16'h4000};
    logic [15:0] bv[3] = '{16'h4200, 16'h0000, 16'h3C00};
    logic [15:0] qv[3] = '{16'h3555, 16'hFC00, 16'h4000};
    logic [3:0]  fv[3] = '{4'b0010,  4'b1001,  4'b0000};
    int          lv[3] = '{14, 1, 14};
    send(av[0], bv[0], mk(qv[0], fv[0], lv[0]));
    for (int i = 1; i < 3; i++) begin
      opA = av[i]; opB = bv[i]; in_valid = 1'b1;
      recv(0);
      @(posedge clock);
      sb.push_back(mk(qv[i], fv[i], lv[i]));
      #1;
      in_valid = 1'b0; opA = 16'($urandom); opB = 16'($urandom);
    end
    recv(0);
  endtask

  task automatic test_reset_mid_op();
    send(16'h3C00, 16'h4000, mk(16'h3800, 4'b0000, 14));
    sb.delete();
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_div got v=%0b r=%0b q=%h want 0/1/0000", out_valid, in_ready, quotient);
    end
    @(posedge clock); #1;
    reset = 1'b0;

    send(16'hBC00, 16'h0000, mk(16'hFC00, 4'b1001, 1));
    sb.delete();
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL done_before_reset got %0b want 1", out_valid); end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || quotient !== 16'h0000 || flags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_done got v=%0b q=%h f=%b want 0/0000/0000", out_valid, quotient, flags);
    end
    @(posedge clock); #1;
    reset = 1'b0;

    send(16'h3C00, 16'h4000, mk(16'h3800, 4'b0000, 14));
    recv(0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_exp_bounds();
    test_special();
    test_stall();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_iter.md
FP_DIV_ITER -- requirements
Module: fp_div_iter

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent width; bias = 2^(EXP_W-1)-1.
REQ-002 SHALL have parameter MAN_W, default 10, stored mantissa width; W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clock  in  1  sole clock, rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_valid  in  1, and in_ready  out  1, for the operand handshake.
REQ-006 SHALL have ports opA, opB  in  W  dividend and divisor, format {sign, exp, man}.
REQ-007 SHALL have ports out_valid  out  1, and out_ready  in  1, for the result handshake.
REQ-008 SHALL have port quotient  out  W  result.
REQ-009 SHALL have ports overflow, underflow, inexact, dbz  out  1  each, valid with out_valid.

Function
REQ-010 SHALL use FSM states IDLE, DIV, NORM, DONE; in_ready=1 only in IDLE.
REQ-011 SHALL accept the operands on an edge where in_valid&in_ready, registering opA/opB.
REQ-012 Special operands SHALL go IDLE->DONE, with out_valid high 1 cycle after acceptance.
REQ-013 All other operands SHALL go IDLE->DIV, run MAN_W+3 cycles in DIV, then 1 cycle in NORM, then DONE; out_valid high MAN_W+4 cycles after acceptance (14 at defaults).
REQ-014 DIV SHALL perform restoring radix-2 division of {1,manA} by {1,manB}, producing one quotient bit per cycle (integer bit plus MAN_W+2 fraction bits) and keeping the remainder.
REQ-015 Exponent SHALL be computed signed in EXP_W+2 bits as eA-eB+bias; if the integer quotient bit is 0, shift the quotient left 1 and decrement the exponent.
REQ-016 Guard SHALL be the first bit below the kept MAN_W; sticky = OR(lower bits, remainder!=0); inexact = guard|sticky.
REQ-017 Rounding-carry out of the mantissa SHALL zero the mantissa and increment the exponent.
REQ-018 Final exponent >= 2^EXP_W-1 SHALL give {sign, all-ones, 0} with overflow=1 and inexact=1.
REQ-019 Final exponent <= 0 SHALL give {sign, 0, 0} with underflow=1 and inexact=1; no subnormal output.
REQ-020 Sign SHALL be signA^signB for every result, including specials.
REQ-021 Operands with exp=0 SHALL be treated as zero, flushing subnormals; exp=all-ones SHALL be treated as infinity, mantissa ignored.
REQ-022 Specials: B zero and A nonzero -> inf, overflow=1, dbz=1. A zero and B nonzero -> zero. 0/0 or inf/inf -> {sign, all-ones, MSB-only mantissa}, dbz=1 for 0/0. A inf -> inf. B inf -> zero. All other flags 0.
REQ-023 In DONE, quotient and flags SHALL stay stable while out_ready=0.
REQ-024 An out_valid&out_ready edge SHALL go DONE->IDLE, with in_ready rising the next cycle and no same-cycle re-accept.
REQ-025 in_valid and operand changes outside IDLE SHALL be ignored.

Reset
REQ-026 Reset SHALL force IDLE asynchronously, including mid-DIV or in DONE, and discard the in-flight operation.
REQ-027 Reset values SHALL be: out_valid=0, quotient=0, all flags 0, internal registers 0; in_ready=1 from the first edge after reset deasserts.

Configuration
REQ-028 Macro FP_DIV_ITER_RNE_EN defined: round-to-nearest-even, incrementing when guard&(sticky|LSB).
REQ-029 Macro FP_DIV_ITER_RNE_EN undefined: truncate, with no increment; inexact and all other behaviour unchanged.

Verification
REQ-030 opA=0x3C00, opB=0x4000 -> quotient=0x3800, all flags 0, out_valid 14 cycles after acceptance.
REQ-031 opA=0x4500, opB=0x4200 -> quotient=0x3EAB (RNE) or 0x3EAA (macro off), inexact=1.
REQ-032 opA=0xBC00, opB=0x0000 -> quotient=0xFC00, overflow=1, dbz=1, out_valid 1 cycle after acceptance.
REQ-033 opA=0x7BFF, opB=0x0400 -> 0x7C00, overflow=1; opA=0x0400, opB=0x7BFF -> 0x0000, underflow=1, inexact=1.
REQ-034 out_ready=0 for 5 cycles in DONE -> quotient stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-035 Reset pulse at DIV cycle 4 -> out_valid=0 immediately; a new op 0x3C00/0x4000 accepted afterwards yields 0x3800.
